// File: rtl/dcache_mem_ctrl.sv
// dcache_mem_ctrl: memory-side miss handler for the data cache.
// On a miss it writes back a dirty victim block as an AXI-style write burst,
// then fetches the missing block as a read burst. The refill is handed to the
// cache with a one-cycle o_block_we, and o_stall holds the pipeline throughout.
// Optional macro DCACHE_MEM_CTRL_PERF_CNT_EN adds o_miss_cnt / o_wb_cnt.
// Ports:
//   i_clk, i_arst (async, active-low)
//   i_mem_access, i_dcache_hit, i_dcache_dirty, i_miss_addr, i_addr_wb, i_data_block_wb
//   o_stall (combinational), o_block_we, o_data_block
//   AW: o_aw_valid/i_aw_ready/o_aw_addr   W: o_w_valid/i_w_ready/o_w_data/o_w_last
//   B : i_b_valid/o_b_ready               AR: o_ar_valid/i_ar_ready/o_ar_addr
//   R : i_r_valid/o_r_ready/i_r_data/i_r_last
module dcache_mem_ctrl #(
   parameter int unsigned ADDR_WIDTH  = 64,
   parameter int unsigned DATA_WIDTH  = 64,
   parameter int unsigned BLOCK_WIDTH = 512
) (
   input  logic                   i_clk,
   input  logic                   i_arst,
   input  logic                   i_mem_access,
   input  logic                   i_dcache_hit,
   input  logic                   i_dcache_dirty,
   input  logic [ADDR_WIDTH-1:0]  i_miss_addr,
   input  logic [ADDR_WIDTH-1:0]  i_addr_wb,
   input  logic [BLOCK_WIDTH-1:0] i_data_block_wb,
   output logic                   o_stall,
   output logic                   o_block_we,
   output logic [BLOCK_WIDTH-1:0] o_data_block,
   output logic                   o_aw_valid,
   input  logic                   i_aw_ready,
   output logic [ADDR_WIDTH-1:0]  o_aw_addr,
   output logic                   o_w_valid,
   input  logic                   i_w_ready,
   output logic [DATA_WIDTH-1:0]  o_w_data,
   output logic                   o_w_last,
   input  logic                   i_b_valid,
   output logic                   o_b_ready,
   output logic                   o_ar_valid,
   input  logic                   i_ar_ready,
   output logic [ADDR_WIDTH-1:0]  o_ar_addr,
   input  logic                   i_r_valid,
   output logic                   o_r_ready,
   input  logic [DATA_WIDTH-1:0]  i_r_data,
   input  logic                   i_r_last
`ifdef DCACHE_MEM_CTRL_PERF_CNT_EN
   ,
   output logic [31:0]            o_miss_cnt,
   output logic [31:0]            o_wb_cnt
`endif
);

   localparam int unsigned BEATS = BLOCK_WIDTH / DATA_WIDTH;
   localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned OFF_W = $clog2(BLOCK_WIDTH / 8);
   localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WB_ADDR = 3'd1;
   localparam logic [2:0] S_WB_DATA = 3'd2;
   localparam logic [2:0] S_WB_RESP = 3'd3;
   localparam logic [2:0] S_RD_ADDR = 3'd4;
   localparam logic [2:0] S_RD_DATA = 3'd5;
   localparam logic [2:0] S_REFILL  = 3'd6;

   logic [2:0]             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]  wb_addr_q, wb_addr_d;
   logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
   logic [BLOCK_WIDTH-1:0] victim_q, victim_d;
   logic [BLOCK_WIDTH-1:0] block_q, block_d;
   logic [DATA_WIDTH-1:0]  w_data_q, w_data_d;
   logic                   aw_valid_q, aw_valid_d;
   logic                   w_valid_q, w_valid_d;
   logic                   w_last_q, w_last_d;
   logic                   b_ready_q, b_ready_d;
   logic                   ar_valid_q, ar_valid_d;
   logic                   r_ready_q, r_ready_d;
   logic                   block_we_q, block_we_d;
   logic                   miss;
`ifdef DCACHE_MEM_CTRL_PERF_CNT_EN
   logic [31:0]            miss_cnt_q, miss_cnt_d;
   logic [31:0]            wb_cnt_q, wb_cnt_d;
`endif

   assign miss    = i_mem_access & ~i_dcache_hit;
   assign o_stall = miss | (state_q != S_IDLE);

   // Next-state, datapath and next-output logic
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wb_addr_d = wb_addr_q;
      rd_addr_d = rd_addr_q;
      victim_d  = victim_q;
      block_d   = block_q;
`ifdef DCACHE_MEM_CTRL_PERF_CNT_EN
      miss_cnt_d = miss_cnt_q;
      wb_cnt_d   = wb_cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (miss) begin
               rd_addr_d = i_miss_addr & ~OFF_MASK;
               // Start each refill from a zeroed block so a short burst leaves unused beats at 0
               block_d   = '0;
               cnt_d     = '0;
`ifdef DCACHE_MEM_CTRL_PERF_CNT_EN
               miss_cnt_d = miss_cnt_q + 32'd1;
`endif
               if (i_dcache_dirty) begin
                  wb_addr_d = i_addr_wb;
                  victim_d  = i_data_block_wb;
                  state_d   = S_WB_ADDR;
`ifdef DCACHE_MEM_CTRL_PERF_CNT_EN
                  wb_cnt_d  = wb_cnt_q + 32'd1;
`endif
               end else begin
                  state_d = S_RD_ADDR;
               end
            end
         end
         S_WB_ADDR: if (i_aw_ready) state_d = S_WB_DATA;
         S_WB_DATA: begin
            if (i_w_ready) begin
               if (cnt_q == LAST_BEAT) begin
                  cnt_d   = '0;
                  state_d = S_WB_RESP;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         S_WB_RESP: if (i_b_valid) state_d = S_RD_ADDR;
         S_RD_ADDR: if (i_ar_ready) state_d = S_RD_DATA;
         S_RD_DATA: begin
            if (i_r_valid) begin
               block_d[32'(cnt_q) * DATA_WIDTH +: DATA_WIDTH] = i_r_data;
               // Burst closes on r_last or at the final beat, whichever comes first
               if (i_r_last || (cnt_q == LAST_BEAT)) begin
                  cnt_d   = '0;
                  state_d = S_REFILL;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         S_REFILL: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase

      // Outputs are registered from the next state so they line up with state_q
      aw_valid_d = (state_d == S_WB_ADDR);
      w_valid_d  = (state_d == S_WB_DATA);
      w_last_d   = (state_d == S_WB_DATA) && (cnt_d == LAST_BEAT);
      w_data_d   = victim_d[32'(cnt_d) * DATA_WIDTH +: DATA_WIDTH];
      b_ready_d  = (state_d == S_WB_RESP);
      ar_valid_d = (state_d == S_RD_ADDR);
      r_ready_d  = (state_d == S_RD_DATA);
      block_we_d = (state_d == S_REFILL);
   end

   // State and output registers
   always_ff @(posedge i_clk or negedge i_arst) begin
      if (!i_arst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         wb_addr_q  <= '0;
         rd_addr_q  <= '0;
         victim_q   <= '0;
         block_q    <= '0;
         w_data_q   <= '0;
         aw_valid_q <= 1'b0;
         w_valid_q  <= 1'b0;
         w_last_q   <= 1'b0;
         b_ready_q  <= 1'b0;
         ar_valid_q <= 1'b0;
         r_ready_q  <= 1'b0;
         block_we_q <= 1'b0;
`ifdef DCACHE_MEM_CTRL_PERF_CNT_EN
         miss_cnt_q <= '0;
         wb_cnt_q   <= '0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wb_addr_q  <= wb_addr_d;
         rd_addr_q  <= rd_addr_d;
         victim_q   <= victim_d;
         block_q    <= block_d;
         w_data_q   <= w_data_d;
         aw_valid_q <= aw_valid_d;
         w_valid_q  <= w_valid_d;
         w_last_q   <= w_last_d;
         b_ready_q  <= b_ready_d;
         ar_valid_q <= ar_valid_d;
         r_ready_q  <= r_ready_d;
         block_we_q <= block_we_d;
`ifdef DCACHE_MEM_CTRL_PERF_CNT_EN
         miss_cnt_q <= miss_cnt_d;
         wb_cnt_q   <= wb_cnt_d;
`endif
      end
   end

   assign o_aw_valid   = aw_valid_q;
   assign o_aw_addr    = wb_addr_q;
   assign o_w_valid    = w_valid_q;
   assign o_w_data     = w_data_q;
   assign o_w_last     = w_last_q;
   assign o_b_ready    = b_ready_q;
   assign o_ar_valid   = ar_valid_q;
   assign o_ar_addr    = rd_addr_q;
   assign o_r_ready    = r_ready_q;
   assign o_block_we   = block_we_q;
   assign o_data_block = block_q;
`ifdef DCACHE_MEM_CTRL_PERF_CNT_EN
   assign o_miss_cnt   = miss_cnt_q;
   assign o_wb_cnt     = wb_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// Self-checking bench for dcache_mem_ctrl: table of single-step miss-detection
// vectors plus hand-written burst sequences driven by a small bus responder.
module tb_dcache_mem_ctrl;
   localparam int unsigned AW = 64;
   localparam int unsigned DW = 64;
   localparam int unsigned BW = 512;
   localparam int unsigned BEATS = 8;

   logic           clk = 1'b0;
   logic           i_arst = 1'b0;
   logic           i_mem_access = 1'b0, i_dcache_hit = 1'b0, i_dcache_dirty = 1'b0;
   logic [AW-1:0]  i_miss_addr = '0, i_addr_wb = '0;
   logic [BW-1:0]  i_data_block_wb = '0;
   logic           o_stall, o_block_we;
   logic [BW-1:0]  o_data_block;
   logic           o_aw_valid, i_aw_ready = 1'b0;
   logic [AW-1:0]  o_aw_addr;
   logic           o_w_valid, i_w_ready = 1'b0, o_w_last;
   logic [DW-1:0]  o_w_data;
   logic           i_b_valid = 1'b0, o_b_ready;
   logic           o_ar_valid, i_ar_ready = 1'b0;
   logic [AW-1:0]  o_ar_addr;
   logic           i_r_valid = 1'b0, o_r_ready, i_r_last = 1'b0;
   logic [DW-1:0]  i_r_data = '0;
`ifdef DCACHE_MEM_CTRL_PERF_CNT_EN
   logic [31:0]    o_miss_cnt, o_wb_cnt;
`endif

   always #5 clk = ~clk;

   dcache_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_WIDTH(BW)) dut (
      .i_clk(clk), .i_arst(i_arst),
      .i_mem_access(i_mem_access), .i_dcache_hit(i_dcache_hit), .i_dcache_dirty(i_dcache_dirty),
      .i_miss_addr(i_miss_addr), .i_addr_wb(i_addr_wb), .i_data_block_wb(i_data_block_wb),
      .o_stall(o_stall), .o_block_we(o_block_we), .o_data_block(o_data_block),
      .o_aw_valid(o_aw_valid), .i_aw_ready(i_aw_ready), .o_aw_addr(o_aw_addr),
      .o_w_valid(o_w_valid), .i_w_ready(i_w_ready), .o_w_data(o_w_data), .o_w_last(o_w_last),
      .i_b_valid(i_b_valid), .o_b_ready(o_b_ready),
      .o_ar_valid(o_ar_valid), .i_ar_ready(i_ar_ready), .o_ar_addr(o_ar_addr),
      .i_r_valid(i_r_valid), .o_r_ready(o_r_ready), .i_r_data(i_r_data), .i_r_last(i_r_last)
`ifdef DCACHE_MEM_CTRL_PERF_CNT_EN
      , .o_miss_cnt(o_miss_cnt), .o_wb_cnt(o_wb_cnt)
`endif
   );

   int n_chk = 0;
   int n_fail = 0;
   logic [BW-1:0] victim;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_blk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] rd_beat(input int i);
      return DW'(17 * (i + 1));
   endfunction

   task automatic bus_idle();
      i_mem_access = 1'b0; i_dcache_hit = 1'b0; i_dcache_dirty = 1'b0;
      i_aw_ready = 1'b0; i_w_ready = 1'b0; i_b_valid = 1'b0;
      i_ar_ready = 1'b0; i_r_valid = 1'b0; i_r_last = 1'b0; i_r_data = '0;
   endtask

   task automatic do_reset();
      bus_idle();
      i_arst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      i_arst = 1'b1;
      @(negedge clk);
   endtask

   task automatic chk_all_zero(input string name);
      chk_blk({name, " outputs"},
              BW'({o_stall, o_block_we, o_aw_valid, o_w_valid, o_w_last, o_b_ready,
                   o_ar_valid, o_r_ready}), '0);
      chk({name, " aw_addr"}, o_aw_addr, 64'h0);
      chk({name, " ar_addr"}, o_ar_addr, 64'h0);
      chk({name, " w_data"}, o_w_data, 64'h0);
      chk_blk({name, " data_block"}, o_data_block, '0);
   endtask

   // Runs one complete miss against a responder; last_beat > 7 means r_last is never sent
   task automatic run_miss(input string tag, input bit dirty, input logic [AW-1:0] maddr,
                           input logic [AW-1:0] waddr, input int last_beat, input int stall,
                           input bit r_tog, input int exp_cycles);
      logic [BW-1:0] exp_blk;
      int wbeat = 0, rbeat = 0, we_cnt = 0, aw_cnt = 0, act_cyc = 0;
      int aw_wait = 0, w_wait = 0, ar_wait = 0, eff_last;
      bit b_done = 0, done = 0, phase = 0, first = 0;
      bit aw_pend = 0, w_pend = 0, ar_pend = 0;
      eff_last = (last_beat > 7) ? 7 : last_beat;
      exp_blk = '0;
      for (int i = 0; i <= eff_last; i++) exp_blk[i*DW +: DW] = rd_beat(i);

      i_mem_access = 1'b1; i_dcache_hit = 1'b0; i_dcache_dirty = dirty;
      i_miss_addr = maddr; i_addr_wb = waddr; i_data_block_wb = victim;
      #1 chk({tag, " stall_same_cycle"}, 64'(o_stall), 64'h1);

      for (int cyc = 0; cyc < 300 && !done; cyc++) begin
         @(negedge clk);
         if (o_aw_valid | o_w_valid | o_b_ready | o_ar_valid | o_r_ready | o_block_we) begin
            act_cyc++;
            if (!first) begin
               first = 1;
               chk({tag, " first_is_aw"}, 64'(o_aw_valid), 64'(dirty));
            end
         end
         if (aw_pend) chk({tag, " aw_held"}, 64'(o_aw_valid), 64'h1);
         if (o_aw_valid) begin
            aw_cnt++;
            chk({tag, " aw_addr"}, o_aw_addr, waddr);
            i_aw_ready = (aw_wait >= stall);
            if (!i_aw_ready) aw_wait++;
            aw_pend = !i_aw_ready;
         end else begin
            i_aw_ready = 1'b0; aw_pend = 0;
         end
         if (w_pend) chk({tag, " w_held"}, 64'(o_w_valid), 64'h1);
         if (o_w_valid) begin
            chk({tag, " w_data"}, o_w_data, victim[(wbeat % 8)*DW +: DW]);
            chk({tag, " w_last"}, 64'(o_w_last), 64'(wbeat == 7));
            i_w_ready = (w_wait >= stall);
            if (!i_w_ready) w_wait++;
            w_pend = !i_w_ready;
            if (i_w_ready) wbeat++;
         end else begin
            i_w_ready = 1'b0; w_pend = 0;
         end
         i_b_valid = o_b_ready;
         if (o_b_ready) begin
            chk({tag, " b_after_w"}, 64'(wbeat), 64'd8);
            b_done = 1;
         end
         if (ar_pend) chk({tag, " ar_held"}, 64'(o_ar_valid), 64'h1);
         if (o_ar_valid) begin
            chk({tag, " ar_addr"}, o_ar_addr, maddr & ~64'h3F);
            chk({tag, " ar_after_b"}, 64'(b_done), 64'(dirty));
            i_ar_ready = (ar_wait >= stall);
            if (!i_ar_ready) ar_wait++;
            ar_pend = !i_ar_ready;
         end else begin
            i_ar_ready = 1'b0; ar_pend = 0;
         end
         if (o_r_ready) begin
            i_r_valid = r_tog ? phase : 1'b1;
            phase = ~phase;
            if (i_r_valid) begin
               i_r_data = rd_beat(rbeat % 8);
               i_r_last = (rbeat == last_beat);
               rbeat++;
            end else begin
               // Junk that must be ignored while r_valid is low
               i_r_data = 64'hBAD0_BAD0_BAD0_BAD0;
               i_r_last = 1'b1;
            end
         end else begin
            i_r_valid = 1'b0; i_r_last = 1'b0;
         end
         if (o_block_we) begin
            we_cnt++;
            chk_blk({tag, " refill_block"}, o_data_block, exp_blk);
            chk({tag, " stall_in_refill"}, 64'(o_stall), 64'h1);
            i_dcache_hit = 1'b1;
            done = 1;
         end
      end
      if (!done) begin
         n_chk++; n_fail++;
         $display("FAIL %s timeout: got no block_we expected one within 300 cycles", tag);
      end
      @(negedge clk);
      chk({tag, " stall_released"}, 64'(o_stall), 64'h0);
      bus_idle();
      repeat (2) begin
         if (o_block_we) we_cnt++;
         @(negedge clk);
      end
      chk({tag, " we_pulses"}, 64'(we_cnt), 64'd1);
      chk({tag, " aw_seen"}, 64'(aw_cnt > 0), 64'(dirty));
      chk({tag, " w_beats"}, 64'(wbeat), dirty ? 64'd8 : 64'd0);
      chk({tag, " r_beats"}, 64'(rbeat), 64'(eff_last + 1));
      if (exp_cycles >= 0) chk({tag, " latency"}, 64'(act_cyc), 64'(exp_cycles));
   endtask

   typedef struct {
      logic          acc, hit, dirty;
      logic [AW-1:0] maddr, waddr;
      logic          exp_stall, exp_aw_v, exp_ar_v;
      logic [AW-1:0] exp_aw_addr, exp_ar_addr;
   } vec_t;

   vec_t vecs[6];

   initial begin
      for (int i = 0; i < 8; i++)
         victim[i*DW +: DW] = 64'hCAFE_0000_0000_0000 | 64'(i * 257 + 1);

      vecs[0] = '{1'b0, 1'b0, 1'b1, 64'h1038, 64'h2000, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0};
      vecs[1] = '{1'b1, 1'b1, 1'b1, 64'h1038, 64'h2000, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0};
      vecs[2] = '{1'b1, 1'b0, 1'b0, 64'h1038, 64'h2000, 1'b1, 1'b0, 1'b1, 64'h0, 64'h1000};
      vecs[3] = '{1'b1, 1'b0, 1'b1, 64'h1038, 64'h2000, 1'b1, 1'b1, 1'b0, 64'h2000, 64'h1000};
      vecs[4] = '{1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 1'b1,
                  64'h0, 64'hFFFF_FFFF_FFFF_FFC0};
      vecs[5] = '{1'b1, 1'b0, 1'b0, 64'h107F, 64'h0, 1'b1, 1'b0, 1'b1, 64'h0, 64'h1040};

      do_reset();
      chk_all_zero("reset");

      // Miss detection and first-step decode, bus held not-ready
      for (int v = 0; v < 6; v++) begin
         i_mem_access = vecs[v].acc; i_dcache_hit = vecs[v].hit; i_dcache_dirty = vecs[v].dirty;
         i_miss_addr = vecs[v].maddr; i_addr_wb = vecs[v].waddr; i_data_block_wb = victim;
         #1 chk($sformatf("vec%0d stall_comb", v), 64'(o_stall), 64'(vecs[v].exp_stall));
         @(negedge clk);
         chk($sformatf("vec%0d aw_valid", v), 64'(o_aw_valid), 64'(vecs[v].exp_aw_v));
         chk($sformatf("vec%0d ar_valid", v), 64'(o_ar_valid), 64'(vecs[v].exp_ar_v));
         chk($sformatf("vec%0d aw_addr", v), o_aw_addr, vecs[v].exp_aw_addr);
         chk($sformatf("vec%0d ar_addr", v), o_ar_addr, vecs[v].exp_ar_addr);
         chk($sformatf("vec%0d stall_held", v), 64'(o_stall), 64'(vecs[v].exp_stall));
         do_reset();
      end

      run_miss("clean", 1'b0, 64'h1038, 64'h0, 7, 0, 1'b0, 10);
      run_miss("dirty", 1'b1, 64'h1038, 64'h2000, 7, 0, 1'b0, 20);
      run_miss("backpr", 1'b1, 64'h4010, 64'h5000, 99, 5, 1'b1, -1);
      run_miss("early_last", 1'b0, 64'h6000, 64'h0, 3, 0, 1'b0, 6);

      // Reset while the writeback is presenting beat 4
      i_mem_access = 1'b1; i_dcache_hit = 1'b0; i_dcache_dirty = 1'b1;
      i_miss_addr = 64'h3000; i_addr_wb = 64'h2000; i_data_block_wb = victim;
      i_aw_ready = 1'b1; i_w_ready = 1'b1;
      repeat (6) @(negedge clk);
      chk("midrst w_valid", 64'(o_w_valid), 64'h1);
      chk("midrst beat4", o_w_data, victim[4*DW +: DW]);
      bus_idle();
      i_arst = 1'b0;
      #1 chk_all_zero("midrst");
      @(negedge clk);
      i_arst = 1'b1;
      @(negedge clk);
      chk_all_zero("after_rst");
      run_miss("restart", 1'b1, 64'h3000, 64'h2000, 7, 0, 1'b0, 20);

`ifdef DCACHE_MEM_CTRL_PERF_CNT_EN
      do_reset();
      chk("perf miss_reset", 64'(o_miss_cnt), 64'd0);
      run_miss("perf1", 1'b0, 64'h7000, 64'h0, 7, 0, 1'b0, 10);
      run_miss("perf2", 1'b1, 64'h7040, 64'h8000, 7, 0, 1'b0, 20);
      run_miss("perf3", 1'b0, 64'h7080, 64'h0, 7, 0, 1'b0, 10);
      chk("perf miss_cnt", 64'(o_miss_cnt), 64'd3);
      chk("perf wb_cnt", 64'(o_wb_cnt), 64'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/dcache_mem_ctrl.md
Name: dcache_mem_ctrl

Overview:
- Memory-side responder for the data cache in the memory stage.
- On a dcache miss it writes back the dirty victim block (if any) as a write burst, then fetches the missing block as a read burst.
- It presents the refill block to the cache with a one-cycle block write enable, and stalls the pipeline throughout.
- Bus side is a simplified AXI-style burst interface with valid/ready on every channel.

Parameters:
- ADDR_WIDTH, 64, byte address width.
- DATA_WIDTH, 64, bus beat width in bits.
- BLOCK_WIDTH, 512, cache block width in bits; BEATS = BLOCK_WIDTH/DATA_WIDTH (default 8).

Ports:
- i_clk  in  1  clock.
- i_arst  in  1  asynchronous reset, active-low.
- i_mem_access  in  1  memory stage holds a load/store.
- i_dcache_hit  in  1  cache hit for the current access.
- i_dcache_dirty  in  1  victim block is dirty.
- i_miss_addr  in  ADDR_WIDTH  address of the missing access.
- i_addr_wb  in  ADDR_WIDTH  victim block base address.
- i_data_block_wb  in  BLOCK_WIDTH  victim block data.
- o_stall  out  1  pipeline stall request.
- o_block_we  out  1  refill write strobe to the cache.
- o_data_block  out  BLOCK_WIDTH  refill block.
- o_aw_valid  out  1 / i_aw_ready  in  1 / o_aw_addr  out  ADDR_WIDTH  write address channel.
- o_w_valid  out  1 / i_w_ready  in  1 / o_w_data  out  DATA_WIDTH / o_w_last  out  1  write data channel.
- i_b_valid  in  1 / o_b_ready  out  1  write response channel.
- o_ar_valid  out  1 / i_ar_ready  in  1 / o_ar_addr  out  ADDR_WIDTH  read address channel.
- i_r_valid  in  1 / o_r_ready  out  1 / i_r_data  in  DATA_WIDTH / i_r_last  in  1  read data channel.

Behaviour:
- Reset: state IDLE; all valid/ready/strobe outputs 0; addresses, o_w_data, o_data_block and the beat counter 0.
- Miss detection: miss = i_mem_access & ~i_dcache_hit.
  - o_stall = miss | (state != IDLE), combinational, so it is asserted in the same cycle as the miss.
- IDLE: on miss, latch the refill base address i_miss_addr with the low log2(BLOCK_WIDTH/8) bits cleared.
  - If i_dcache_dirty: also latch i_addr_wb and i_data_block_wb, then go to WB_ADDR.
  - Otherwise go to RD_ADDR.
- WB_ADDR: o_aw_valid=1, o_aw_addr = latched victim address; the valid is held until i_aw_ready, then go to WB_DATA.
- WB_DATA: o_w_valid=1; o_w_data = victim beat[cnt], beat 0 = bits [DATA_WIDTH-1:0].
  - o_w_last=1 when cnt == BEATS-1.
  - cnt increments on each w handshake; after the last beat, cnt returns to 0 and state goes to WB_RESP.
- WB_RESP: o_b_ready=1; on i_b_valid go to RD_ADDR. Response code is ignored.
- RD_ADDR: o_ar_valid=1, o_ar_addr = latched refill address; on i_ar_ready go to RD_DATA.
- RD_DATA: o_r_ready=1; each r handshake stores i_r_data into o_data_block beat[cnt] and increments cnt.
  - The burst ends on the handshake with i_r_last=1 or at cnt == BEATS-1, whichever comes first; then go to REFILL.
  - A beat beyond BEATS-1 is never written.
- REFILL: o_block_we=1 for exactly one cycle with the complete o_data_block; go to IDLE.
  - o_stall is still 1 in REFILL. The cache shows a hit the following cycle, and the stage re-executes.
- Latency: no stall-side handshake delays, zero-wait bus:
  - Clean miss: 1 + BEATS + 1 = 10 cycles from entering RD_ADDR through REFILL.
  - Dirty miss: additionally 1 + BEATS + 1 cycles for writeback.
- Single outstanding transaction only. Inputs are ignored outside IDLE; new misses are only sampled in IDLE.
- Valid signals never drop before their handshake; address and data stay stable while valid is high without ready.
- Reset mid-burst: immediate return to IDLE with all outputs at reset values; no bus completion is attempted.

Optional Feature:
- Macro DCACHE_MEM_CTRL_PERF_CNT_EN.
- When defined: adds 32-bit outputs o_miss_cnt and o_wb_cnt.
  - o_miss_cnt increments when a miss is accepted in IDLE.
  - o_wb_cnt increments when a dirty miss is accepted.
  - Both wrap at 2^32 - 1 to 0 and reset to 0.
- When undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Clean miss, i_miss_addr=0x1038, zero-wait bus:
  - o_ar_addr=0x1000; no aw activity.
  - 8 beats 0x11..0x88 give o_data_block beat0=0x11 ... beat7=0x88.
  - o_block_we pulses exactly once; o_stall is released the cycle after REFILL.
- Dirty miss, i_addr_wb=0x2000:
  - aw 0x2000 precedes ar.
  - w beats equal the victim block slices in order; o_w_last only on beat 7.
  - ar is issued only after the b handshake.
- Backpressure: i_aw_ready, i_w_ready and i_ar_ready held low 5 cycles, and i_r_valid toggled every other cycle -> valids held, data stable, final block correct.
- Early i_r_last on beat 3 -> REFILL entered after 4 beats, beats 4-7 stay 0.
- i_arst asserted low during WB_DATA beat 4 -> all outputs 0 immediately; the next miss restarts cleanly from WB_ADDR.
- With DCACHE_MEM_CTRL_PERF_CNT_EN: 3 misses, 1 of them dirty -> o_miss_cnt=3, o_wb_cnt=1.
